muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit_if.sv | 24 ++
 rtl/muldiv_unit.sv | 95 +++++++++
 2 files changed

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: handshake and result bus of the HI/LO multiply-divide unit
// master (pipeline side) drives start/op/a/b/flush and receives ready/busy and the HI/LO write strobes with data;
// slave (muldiv_unit) is the mirror image.
interface muldiv_unit_if;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        flush;
   logic        ready;
   logic        busy;
   logic        hi_write;
   logic        lo_write;
   logic [31:0] hi_data;
   logic [31:0] lo_data;
   modport master (
      output start, op, a, b, flush,
      input  ready, busy, hi_write, lo_write, hi_data, lo_data
   );
   modport slave (
      input  start, op, a, b, flush,
      output ready, busy, hi_write, lo_write, hi_data, lo_data
   );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: MIPS-style HI/LO multiply (1 cycle) and restoring divide (32 cycles) unit
// clk/resetn: rising-edge clock, asynchronous active-low reset.
// bus (slave): start/op/a/b accepted when start & ready; flush aborts MUL/DIV;
//              ready/busy track IDLE; hi/lo strobes and data are nonzero only in DONE.
module muldiv_unit (
   input  logic         clk,
   input  logic         resetn,
   muldiv_unit_if.slave bus
);
   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;
   state_e      state_q, state_d;
   logic        sgn_q, sgn_d;
   logic [31:0] a_q, a_d, b_q, b_d;
   logic [31:0] rem_q, rem_d, quo_q, quo_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [63:0] prod;
   logic [31:0] dvs, rem_nx, quo_nx, hi_div, lo_div;
   logic [32:0] r_sh, diff;
   // operands sign-extended to 64 bits when signed, so one unsigned multiply covers MULT and MULTU
   assign prod = {{32{sgn_q & a_q[31]}}, a_q} * {{32{sgn_q & b_q[31]}}, b_q};
   assign dvs = (sgn_q & b_q[31]) ? -b_q : b_q;
   // quo_q starts as the dividend magnitude and shifts its bits into the partial remainder
   assign r_sh = {rem_q, quo_q[31]};
   assign diff = r_sh - {1'b0, dvs};
   assign rem_nx = diff[32] ? r_sh[31:0] : diff[31:0];
   assign quo_nx = {quo_q[30:0], ~diff[32]};
   // divide-by-zero is reported as all-ones quotient with the raw dividend as remainder
   assign hi_div = (b_q == '0) ? a_q : (sgn_q & a_q[31]) ? -rem_nx : rem_nx;
   assign lo_div = (b_q == '0) ? '1 : (sgn_q & (a_q[31] ^ b_q[31])) ? -quo_nx : quo_nx;
   always_comb begin
      state_d = state_q;
      sgn_d = sgn_q;
      a_d = a_q;
      b_d = b_q;
      cnt_d = cnt_q;
      rem_d = rem_q;
      quo_d = quo_q;
      hi_d = hi_q;
      lo_d = lo_q;
      case (state_q)
         IDLE: if (bus.start && !bus.flush) begin
            state_d = bus.op[1] ? DIV : MUL;
            sgn_d = ~bus.op[0];
            a_d = bus.a;
            b_d = bus.b;
            cnt_d = '0;
            rem_d = '0;
            quo_d = (~bus.op[0] & bus.a[31]) ? -bus.a : bus.a;
         end
         MUL: begin
            state_d = bus.flush ? IDLE : DONE;
            {hi_d, lo_d} = bus.flush ? {hi_q, lo_q} : prod;
         end
         DIV: begin
            cnt_d = cnt_q + 5'd1;
            rem_d = rem_nx;
            quo_d = quo_nx;
            state_d = bus.flush ? IDLE : (cnt_q == 5'd31) ? DONE : DIV;
            hi_d = (!bus.flush && cnt_q == 5'd31) ? hi_div : hi_q;
            lo_d = (!bus.flush && cnt_q == 5'd31) ? lo_div : lo_q;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         sgn_q <= 1'b0;
         a_q <= '0;
         b_q <= '0;
         cnt_q <= '0;
         rem_q <= '0;
         quo_q <= '0;
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         state_q <= state_d;
         sgn_q <= sgn_d;
         a_q <= a_d;
         b_q <= b_d;
         cnt_q <= cnt_d;
         rem_q <= rem_d;
         quo_q <= quo_d;
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end
   assign bus.ready = (state_q == IDLE);
   assign bus.busy = (state_q != IDLE);
   assign bus.hi_write = (state_q == DONE);
   assign bus.lo_write = (state_q == DONE);
   assign bus.hi_data = (state_q == DONE) ? hi_q : '0;
   assign bus.lo_data = (state_q == DONE) ? lo_q : '0;
endmodule
